// File: rtl/video_pattern_writer.sv
// Test-pattern frame writer: each armed vsync rising edge streams one frame of
// generated pixels as bus write beats, with a bounded number of writes in flight.
module video_pattern_writer #(
  parameter int          HRES     = 640,
  parameter int          VRES     = 480,
  parameter int          PIX_BITS = 32,
  parameter int          BUS_BITS = 128,
  parameter logic [31:0] BASE_ADR = 32'h0,
  parameter int          MAX_OUT  = 4,
  parameter int          CK_SHIFT = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [2:0]            mode_i,
  input  logic [PIX_BITS-1:0]   color_i,
  input  logic                  vsync_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [31:0]           req_adr_o,
  output logic [BUS_BITS-1:0]   req_dat_o,
  output logic [BUS_BITS/8-1:0] req_sel_o,
  input  logic                  resp_ack_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic [15:0]           frame_cnt_o
);

  localparam int          PPW       = BUS_BITS / PIX_BITS;
  localparam int          BPB       = BUS_BITS / 8;
  localparam int          BAR_W     = HRES / 8;
  localparam logic [31:0] LAST_BEAT = 32'(HRES * VRES / PPW - 1);
  localparam logic [3:0]  MAX_OUT_L = 4'(MAX_OUT);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WRITE, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic                  vsync_q;
  logic [3:0]            out_q, out_d;
  logic [31:0]           beat_q, beat_d, x_q, x_d, y_q, y_d;
  logic [2:0]            bar_q, bar_d, barn_q, bar_s;
  logic [31:0]           barc_q, barc_d, barcn_q, barc_s;
  logic [2:0]            mode_q, mode_n;
  logic [PIX_BITS-1:0]   color_q, color_n;
  logic                  valid_q, valid_d;
  logic [31:0]           adr_q;
  logic [BUS_BITS-1:0]   dat_q, dat_d;
  logic [BUS_BITS/8-1:0] sel_q;
  logic                  busy_q, done_q;
  logic [15:0]           cnt_q;
  logic                  accept_s, ack_s, start_s, exit_s;

  function automatic logic [PIX_BITS-1:0] pix_fn(
    input logic [2:0]          m,
    input logic [PIX_BITS-1:0] c,
    input logic [31:0]         px,
    input logic [31:0]         py,
    input logic [2:0]          bar,
    input logic [31:0]         lin
  );
    logic [31:0]         t;
    logic [PIX_BITS-1:0] r;
    t = 32'd0;
    r = {PIX_BITS{1'b0}};
    case (m)
      3'd0: r = c;
      3'd1: r = px[PIX_BITS-1:0];
      3'd2: begin
        t = (px >> CK_SHIFT) ^ (py >> CK_SHIFT);
        r = t[0] ? ~c : c;
      end
      3'd3: for (int i = 0; i < PIX_BITS; i++) r[i] = bar[(3 * i) / PIX_BITS];
      3'd4: r = lin[PIX_BITS-1:0];
      default: r = {PIX_BITS{1'b0}};
    endcase
    return r;
  endfunction

  // Handshake qualification and outstanding-write bookkeeping
  always_comb begin
    accept_s = valid_q & req_ready_i;
    ack_s    = resp_ack_i & (out_q != 4'd0);
    out_d    = out_q;
    if (accept_s && !ack_s) out_d = out_q + 4'd1;
    else if (!accept_s && ack_s) out_d = out_q - 4'd1;
    else out_d = out_q;
  end

  // Frame sequencing FSM next state
  always_comb begin
    state_d = state_q;
    start_s = 1'b0;
    exit_s  = 1'b0;
    case (state_q)
      S_IDLE:  if (en_i) state_d = S_ARM; else state_d = S_IDLE;
      S_ARM: begin
        if (!en_i) state_d = S_IDLE;
        else if (vsync_i && !vsync_q) begin
          state_d = S_WRITE;
          start_s = 1'b1;
        end else state_d = S_ARM;
      end
      S_WRITE: if (accept_s && beat_q == LAST_BEAT) state_d = S_DRAIN; else state_d = S_WRITE;
      S_DRAIN: begin
        if (out_d == 4'd0) begin
          exit_s  = 1'b1;
          state_d = en_i ? S_ARM : S_IDLE;
        end else state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Raster position of the beat to present next, and the pattern it carries
  always_comb begin
    beat_d  = beat_q;
    x_d     = x_q;
    y_d     = y_q;
    bar_d   = bar_q;
    barc_d  = barc_q;
    mode_n  = start_s ? mode_i : mode_q;
    color_n = start_s ? color_i : color_q;
    if (start_s) begin
      beat_d = 32'd0;
      x_d    = 32'd0;
      y_d    = 32'd0;
      bar_d  = 3'd0;
      barc_d = 32'd0;
    end else if (accept_s) begin
      beat_d = beat_q + 32'd1;
      if (x_q + 32'(PPW) == 32'(HRES)) begin
        x_d    = 32'd0;
        y_d    = y_q + 32'd1;
        bar_d  = 3'd0;
        barc_d = 32'd0;
      end else begin
        x_d    = x_q + 32'(PPW);
        bar_d  = barn_q;
        barc_d = barcn_q;
      end
    end else begin
      beat_d = beat_q;
    end
    // Bar index steps per pixel so bars narrower than a beat still land right
    bar_s  = bar_d;
    barc_s = barc_d;
    dat_d  = {BUS_BITS{1'b0}};
    for (int k = 0; k < PPW; k++) begin
      dat_d[k*PIX_BITS +: PIX_BITS] = pix_fn(mode_n, color_n, x_d + 32'(k), y_d, bar_s,
                                             beat_d * 32'(PPW) + 32'(k) + {16'd0, cnt_q});
      if (barc_s + 32'd1 == 32'(BAR_W)) begin
        barc_s = 32'd0;
        bar_s  = bar_s + 3'd1;
      end else begin
        barc_s = barc_s + 32'd1;
      end
    end
    valid_d = (state_d == S_WRITE) && (out_d < MAX_OUT_L);
  end

  // State, counters and registered request/status outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      vsync_q <= 1'b0;
      out_q   <= 4'd0;
      beat_q  <= 32'd0;
      x_q     <= 32'd0;
      y_q     <= 32'd0;
      bar_q   <= 3'd0;
      barc_q  <= 32'd0;
      barn_q  <= 3'd0;
      barcn_q <= 32'd0;
      mode_q  <= 3'd0;
      color_q <= {PIX_BITS{1'b0}};
      valid_q <= 1'b0;
      adr_q   <= 32'd0;
      dat_q   <= {BUS_BITS{1'b0}};
      sel_q   <= {(BUS_BITS/8){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync_i;
      out_q   <= out_d;
      beat_q  <= beat_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bar_q   <= bar_d;
      barc_q  <= barc_d;
      barn_q  <= bar_s;
      barcn_q <= barc_s;
      mode_q  <= mode_n;
      color_q <= color_n;
      valid_q <= valid_d;
      if (state_d == S_WRITE && (!valid_q || accept_s)) begin
        adr_q <= BASE_ADR + beat_d * 32'(BPB);
        dat_q <= dat_d;
      end else begin
        adr_q <= adr_q;
        dat_q <= dat_q;
      end
      sel_q   <= valid_d ? {(BUS_BITS/8){1'b1}} : {(BUS_BITS/8){1'b0}};
      if (start_s) busy_q <= 1'b1;
      else if (exit_s) busy_q <= 1'b0;
      else busy_q <= busy_q;
      done_q  <= exit_s;
      cnt_q   <= exit_s ? cnt_q + 16'd1 : cnt_q;
    end
  end

  assign req_valid_o  = valid_q;
  assign req_adr_o    = adr_q;
  assign req_dat_o    = dat_q;
  assign req_sel_o    = sel_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign frame_cnt_o  = cnt_q;

endmodule
